// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative radix-2 MUL/DIV sequencer for the EX stage
module ex_muldiv_seq #(
    parameter int         WIDTH  = 32,
    parameter logic [3:0] OP_MUL = 4'b1000,
    parameter logic [3:0] OP_DIV = 4'b1100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op_ex,
    input  logic [WIDTH-1:0] a_ex,
    input  logic [WIDTH-1:0] b_ex,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] ans_md
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    // acc: product accumulator / partial remainder
    // opa: multiplier (shifts right) / dividend with quotient shifting in (shifts left)
    // opb: multiplicand (shifts left) / divisor
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic             is_md;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_bit;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_q_next;

    assign is_md = start & ((op_ex == OP_MUL) | (op_ex == OP_DIV));

    always_comb begin
        mul_acc_next = opa[0] ? acc + opb : acc;
        div_shift    = {acc, opa[WIDTH-1]};
        div_diff     = div_shift - {1'b0, opb};
        div_bit      = ~div_diff[WIDTH];
        div_rem_next = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_q_next   = {opa[WIDTH-2:0], div_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            ans_md <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_md && !flush) begin
                        acc   <= '0;
                        opa   <= a_ex;
                        opb   <= b_ex;
                        count <= CW'(WIDTH - 1);
                        if (op_ex == OP_MUL) begin
                            state <= S_MUL;
                        end else if (b_ex == '0) begin
                            ans_md <= '1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= mul_acc_next;
                        opa <= opa >> 1;
                        opb <= opb << 1;
                        if (count == '0) begin
                            ans_md <= mul_acc_next;
                            state  <= S_DONE;
                        end else begin
                            count <= count - CW'(1);
                        end
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= div_rem_next;
                        opa <= div_q_next;
                        if (count == '0) begin
                            ans_md <= div_q_next;
                            state  <= S_DONE;
                        end else begin
                            count <= count - CW'(1);
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    // A squash must release the pipeline in the same cycle it arrives.
    assign stall = ~flush & (((state == S_IDLE) & is_md) | (state == S_MUL) | (state == S_DIV));

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - randomized self-checking bench for ex_muldiv_seq
module tb_ex_muldiv_seq;

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op_ex;
    logic [31:0] a_ex;
    logic [31:0] b_ex;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] ans_md;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_muldiv_seq #(.WIDTH(32), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_ex  (op_ex),
        .a_ex   (a_ex),
        .b_ex   (b_ex),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .ans_md (ans_md)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        if (op == OP_MUL) begin
            prod = 64'(a) * 64'(b);
            return prod[31:0];
        end
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
    endfunction

    // Issue one op, optionally hammer start with junk while it runs, and check result/timing.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noise);
        logic [31:0] exp;
        int          stalls;
        bit          seen;
        exp   = model(op, a, b);
        start = 1'b1; op_ex = op; a_ex = a; b_ex = b;
        #1;
        stalls = int'(stall);
        seen   = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk); #1;
            if (noise) begin
                start = 1'b1;
                op_ex = ($urandom_range(0, 1) != 0) ? OP_MUL : OP_DIV;
                a_ex  = $urandom;
                b_ex  = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                seen = 1'b1;
                check({tag, "_ans"}, ans_md, exp);
                check({tag, "_stall_in_done"}, stall, 0);
            end else begin
                stalls += int'(stall);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_stall_cycles"}, stalls, (op == OP_DIV && b == 0) ? 1 : 33);
        @(posedge clk); #2;
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulse_len"}, done, 0);
        check({tag, "_ans_held"}, ans_md, exp);
    endtask

    // Start DIV 100/7 and abort it at iteration 10 with flush (use_rst=0) or rst (use_rst=1).
    task automatic abort_test(input string tag, input bit use_rst, input logic [31:0] prev);
        int dones;
        start = 1'b1; op_ex = OP_DIV; a_ex = 100; b_ex = 7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        #1;
        if (!use_rst) check({tag, "_stall_drop"}, stall, 0);
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        #1;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ans"}, ans_md, use_rst ? 32'h0 : prev);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #2;
            dones += int'(done);
        end
        check({tag, "_no_late_done"}, dones, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_ex = 4'b0; a_ex = '0; b_ex = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_busy", busy, 0);
        check("reset_stall", stall, 0);
        check("reset_done", done, 0);
        check("reset_ans", ans_md, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul_7x6", OP_MUL, 7, 6, 1'b0);
        run_op("mul_ffff_x2", OP_MUL, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("mul_ovf", OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_op("div_100_7", OP_DIV, 100, 7, 1'b0);
        run_op("div_msb_1", OP_DIV, 32'h8000_0000, 1, 1'b0);
        run_op("div_by_0", OP_DIV, 5, 0, 1'b0);

        run_op("mul_3x4", OP_MUL, 3, 4, 1'b0);
        abort_test("flush_div", 1'b0, 32'd12);
        abort_test("rst_div", 1'b1, 32'd12);
        run_op("mul_2x3", OP_MUL, 2, 3, 1'b0);

        start = 1'b1; op_ex = 4'b0000; a_ex = 9; b_ex = 9;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("add_ignored_stall", stall, 0);
            @(posedge clk); #2;
            check("add_ignored_busy", busy, 0);
        end
        start = 1'b0;
        @(posedge clk); #1;

        run_op("mul_noise", OP_MUL, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
        run_op("div_noise", OP_DIV, 32'hDEAD_BEEF, 32'h0000_0123, 1'b1);

        for (int i = 0; i < 20; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = ($urandom_range(0, 1) != 0) ? OP_MUL : OP_DIV;
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 0;
                1:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, $urandom_range(0, 1) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
